// File: rtl/prog_loader.sv
// prog_loader: receives a framed program image over a byte stream, writes it
// into local instruction memory and holds the CPU in reset until a complete,
// checksum-verified image is present. It then serves CPU instruction fetches.
//
// Frame: A5, N (1..DEPTH), 2N data bytes (high byte first), checksum.
// The checksum is the 8-bit wrapping sum of the data bytes only.
//
// Ports:
//   CK     clock, all state on posedge
//   RST    synchronous active-high reset
//   RXV    byte strobe, RXD valid on a posedge where RXV=1
//   RXD    received byte
//   IA     CPU instruction address
//   ID     instruction word, combinational read of mem[IA] (0 outside DEPTH)
//   CPURST 1 = CPU held in reset
//   DONE   1 = valid image loaded, CPU running
//   ERR    sticky error from the last frame attempt
module prog_loader #(
   parameter int unsigned DEPTH   = 128,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic        CK,
   input  logic        RST,
   input  logic        RXV,
   input  logic [7:0]  RXD,
   input  logic [15:0] IA,
   output logic [15:0] ID,
   output logic        CPURST,
   output logic        DONE,
   output logic        ERR
);

   localparam int unsigned AW   = $clog2(DEPTH);
   localparam int unsigned TW   = $clog2(TIMEOUT);
   localparam logic [7:0]  SYNC = 8'hA5;

   typedef enum logic [2:0] {
      S_IDLE,
      S_COUNT,
      S_HI,
      S_LO,
      S_CSUM,
      S_RUN
   } state_t;

   state_t        state_q;
   logic [7:0]    wcnt_q;
   logic [7:0]    n_q;
   logic [7:0]    hi_q;
   logic [7:0]    sum_q;
   logic [TW-1:0] timer_q;
   logic          cpurst_q;
   logic          done_q;
   logic          err_q;
   logic [15:0]   mem [DEPTH];

   logic in_frame_c;
   logic timeout_c;

   // Inter-byte timer only matters while a frame is in progress.
   assign in_frame_c = (state_q == S_COUNT) || (state_q == S_HI) ||
                       (state_q == S_LO)    || (state_q == S_CSUM);
   // Fires on the edge where the timer would reach TIMEOUT-1; a byte on the
   // same edge wins.
   assign timeout_c  = in_frame_c && !RXV && (timer_q == TW'(TIMEOUT - 2));

   // Loader FSM, counters and memory write port.
   always_ff @(posedge CK) begin
      if (RST) begin
         state_q  <= S_IDLE;
         wcnt_q   <= '0;
         n_q      <= '0;
         hi_q     <= '0;
         sum_q    <= '0;
         timer_q  <= '0;
         cpurst_q <= 1'b1;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         if (RXV || !in_frame_c || timeout_c)
            timer_q <= '0;
         else
            timer_q <= timer_q + TW'(1);

         if (timeout_c) begin
            state_q <= S_IDLE;
            err_q   <= 1'b1;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (RXV && RXD == SYNC) begin
                     state_q <= S_COUNT;
                     err_q   <= 1'b0;
                     sum_q   <= '0;
                     wcnt_q  <= '0;
                  end
               end
               S_COUNT: begin
                  if (RXV) begin
                     if (RXD == 8'd0 || RXD > 8'(DEPTH)) begin
                        state_q <= S_IDLE;
                        err_q   <= 1'b1;
                     end else begin
                        n_q     <= RXD;
                        state_q <= S_HI;
                     end
                  end
               end
               S_HI: begin
                  if (RXV) begin
                     hi_q    <= RXD;
                     sum_q   <= sum_q + RXD;
                     state_q <= S_LO;
                  end
               end
               S_LO: begin
                  if (RXV) begin
                     mem[wcnt_q[AW-1:0]] <= {hi_q, RXD};
                     sum_q  <= sum_q + RXD;
                     wcnt_q <= wcnt_q + 8'd1;
                     state_q <= (wcnt_q + 8'd1 == n_q) ? S_CSUM : S_HI;
                  end
               end
               S_CSUM: begin
                  if (RXV) begin
                     if (RXD == sum_q) begin
                        state_q  <= S_RUN;
                        cpurst_q <= 1'b0;
                        done_q   <= 1'b1;
                     end else begin
                        state_q <= S_IDLE;
                        err_q   <= 1'b1;
                     end
                  end
               end
               S_RUN: begin
                  // A new sync byte restarts loading and re-holds the CPU.
                  if (RXV && RXD == SYNC) begin
                     state_q  <= S_COUNT;
                     cpurst_q <= 1'b1;
                     done_q   <= 1'b0;
                     err_q    <= 1'b0;
                     sum_q    <= '0;
                     wcnt_q   <= '0;
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   // Zero-latency fetch port; addresses beyond the memory read as zero.
   assign ID     = (IA[15:AW] == '0) ? mem[IA[AW-1:0]] : 16'h0000;
   assign CPURST = cpurst_q;
   assign DONE   = done_q;
   assign ERR    = err_q;

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

   localparam int unsigned TIMEOUT = 1024;

   logic        CK;
   logic        RST;
   logic        RXV;
   logic [7:0]  RXD;
   logic [15:0] IA;
   logic [15:0] ID;
   logic        CPURST;
   logic        DONE;
   logic        ERR;

   int n_vec;
   int n_err;

   prog_loader #(.DEPTH(128), .TIMEOUT(TIMEOUT)) dut (
      .CK(CK), .RST(RST), .RXV(RXV), .RXD(RXD), .IA(IA),
      .ID(ID), .CPURST(CPURST), .DONE(DONE), .ERR(ERR)
   );

   initial CK = 1'b0;
   always #5 CK = ~CK;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present one byte for one posedge; returns 1 time unit after that edge.
   task automatic send(input logic [7:0] b);
      RXV = 1'b1;
      RXD = b;
      @(posedge CK);
      #1;
      RXV = 1'b0;
   endtask

   task automatic status(input string tag, input logic c, input logic d, input logic e);
      chk({tag, ".cpurst"}, 16'(CPURST), 16'(c));
      chk({tag, ".done"},   16'(DONE),   16'(d));
      chk({tag, ".err"},    16'(ERR),    16'(e));
   endtask

   task automatic fetch(input string tag, input logic [15:0] a, input logic [15:0] exp);
      IA = a;
      #1;
      chk(tag, ID, exp);
   endtask

   task automatic send_good3();
      send(8'hA5); send(8'h03);
      send(8'hC0); send(8'h00);
      send(8'hC1); send(8'h01);
      send(8'hC2); send(8'h02);
      send(8'h46);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      RST = 1'b1; RXV = 1'b0; RXD = 8'h00; IA = 16'h0000;
      repeat (2) @(posedge CK);
      #1;
      status("reset", 1'b1, 1'b0, 1'b0);
      RST = 1'b0;

      // Good 3-word load
      send(8'hA5); send(8'h03);
      send(8'hC0); send(8'h00);
      send(8'hC1); send(8'h01);
      send(8'hC2); send(8'h02);
      status("pre_csum", 1'b1, 1'b0, 1'b0);
      send(8'h46);
      status("load3", 1'b0, 1'b1, 1'b0);
      fetch("id0", 16'h0000, 16'hC000);
      fetch("id1", 16'h0001, 16'hC101);
      fetch("id2", 16'h0002, 16'hC202);
      fetch("id80", 16'h0080, 16'h0000);
      IA = 16'h0000;

      // Bad checksum from RUN
      send(8'hA5);
      status("reload_sync", 1'b1, 1'b0, 1'b0);
      send(8'h03);
      send(8'hC0); send(8'h00);
      send(8'hC1); send(8'h01);
      send(8'hC2); send(8'h02);
      send(8'h47);
      status("bad_csum", 1'b1, 1'b0, 1'b1);
      send(8'hA5);
      chk("err_clr_on_sync", 16'(ERR), 16'h0);
      send(8'h03);
      send(8'hC0); send(8'h00);
      send(8'hC1); send(8'h01);
      send(8'hC2); send(8'h02);
      send(8'h46);
      status("recover", 1'b0, 1'b1, 1'b0);

      // Illegal counts
      send(8'hA5); send(8'h00);
      status("cnt00", 1'b1, 1'b0, 1'b1);
      fetch("cnt00_id1", 16'h0001, 16'hC101);
      send(8'hA5);
      chk("cnt81_sync_err", 16'(ERR), 16'h0);
      send(8'h81);
      status("cnt81", 1'b1, 1'b0, 1'b1);
      fetch("cnt81_id2", 16'h0002, 16'hC202);

      // Inter-byte timeout after HI byte of word 1
      send(8'hA5); send(8'h03);
      send(8'hC0); send(8'h00);
      send(8'hD1);
      repeat (TIMEOUT - 2) @(posedge CK);
      #1;
      chk("to_early", 16'(ERR), 16'h0);
      @(posedge CK);
      #1;
      status("timeout", 1'b1, 1'b0, 1'b1);
      send(8'h00);
      chk("stray_err", 16'(ERR), 16'h1);
      send(8'h46);
      chk("idle_ignores", 16'(DONE), 16'h0);
      fetch("to_id1", 16'h0001, 16'hC101);

      // Reload in RUN with a 1-word image
      send_good3();
      status("pre_reload", 1'b0, 1'b1, 1'b0);
      send(8'hA5);
      status("run_sync", 1'b1, 1'b0, 1'b0);
      send(8'h01); send(8'h12); send(8'h34);
      send(8'h46);
      status("reload1", 1'b0, 1'b1, 1'b0);
      fetch("rl_id0", 16'h0000, 16'h1234);
      fetch("rl_id1", 16'h0001, 16'hC101);
      fetch("rl_id2", 16'h0002, 16'hC202);

      // RST mid-frame, byte on the same edge dropped
      send(8'hA5); send(8'h02);
      send(8'hAA); send(8'hBB);
      fetch("partial_id0", 16'h0000, 16'hAABB);
      RST = 1'b1;
      send(8'hA5);
      RST = 1'b0;
      status("rst_mid", 1'b1, 1'b0, 1'b0);
      send(8'h02);
      chk("rst_idle", 16'(ERR), 16'h0);
      send(8'hA5); send(8'h02);
      send(8'h11); send(8'h22);
      send(8'h33); send(8'h44);
      send(8'hAA);
      status("post_rst", 1'b0, 1'b1, 1'b0);
      fetch("pr_id0", 16'h0000, 16'h1122);
      fetch("pr_id1", 16'h0001, 16'h3344);
      fetch("pr_id2", 16'h0002, 16'hC202);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
# prog_loader

Upstream program loader for the 16-bit four-stage CPU. Receives a program as a framed byte stream, writes it into a local instruction memory, and holds the CPU in reset until a complete, checksum-verified image is present. Then releases the CPU and serves its instruction fetches (IA → ID) from that memory. This block replaces the bench-side instruction ROM.

## Interface
- DEPTH, 128: instruction words stored; address = IA[6:0].
- TIMEOUT, 1024: idle cycles allowed between bytes inside a frame.
- CK  in  1  clock, all state on posedge.
- RST  in  1  reset, synchronous, active-high.
- RXV  in  1  byte strobe; RXD is valid on a posedge where RXV=1.
- RXD  in  8  received byte.
- IA  in  16  CPU instruction address.
- ID  out  16  instruction word, combinational read: mem[IA[6:0]] if IA[15:7]==0, else 16'h0000.
- CPURST  out  1  reset to the CPU; 1 = CPU held in reset.
- DONE  out  1  1 = valid image loaded, CPU running.
- ERR  out  1  sticky error from the last frame attempt.

## Operation
- Frame format: sync byte 8'hA5, count byte N (1..DEPTH), then 2N data bytes (high byte first per word), then checksum byte.
- Checksum = 8-bit wrapping sum of the 2N data bytes only. Sync and count bytes are excluded.
- States: IDLE, COUNT, HI, LO, CSUM, RUN.
- IDLE:
  - RXV with RXD=A5 → COUNT. Clear ERR, sum, and word counter wcnt.
  - Any other byte is ignored.
- COUNT:
  - N=0 or N>DEPTH → IDLE with ERR=1.
  - Otherwise latch N → HI.
- HI: latch byte as hi; sum += byte → LO.
- LO:
  - Write mem[wcnt] <= {hi, RXD}; sum += RXD; wcnt++.
  - If wcnt (after increment) == N → CSUM, else → HI.
- CSUM:
  - RXD==sum → RUN: CPURST=0, DONE=1.
  - Otherwise → IDLE with ERR=1; CPURST stays 1.
- RUN:
  - Bytes are ignored except A5.
  - A5 → COUNT, with CPURST=1, DONE=0, ERR=0 on that same edge (reload).
- Memory is written in place. Words ≥N keep their prior contents. A failed frame may leave partial writes; the CPU is still held in reset in that case.
- Memory contents are not cleared by RST.

## Timing
- Reset values:
  - State IDLE; wcnt=0, sum=0, timer=0.
  - CPURST=1, DONE=0, ERR=0.
  - ID follows memory, contents undefined until first load.
- One byte is consumed per posedge with RXV=1. Back-to-back strobes on consecutive cycles are legal.
- Memory write takes effect at the posedge that consumes the LO byte. ID reflects the write combinationally after that edge.
- CPURST falls at the same posedge that consumes a correct checksum byte, so the CPU's first fetch stage (PC=0) follows on the next edge.
- ID has zero latency relative to IA. The CPU samples ID at the posedge one cycle after PC updates.
- Timeout:
  - The timer runs in COUNT/HI/LO/CSUM and is cleared on every RXV.
  - When timer reaches TIMEOUT-1 with no RXV → IDLE with ERR=1.
  - RXV on that same edge takes priority: the byte is consumed and the timer is cleared.
- RST mid-frame or in RUN: return to reset values on that edge. The CPU is held in reset and the image must be reloaded to run.
- RXV and RST on the same edge: RST wins and the byte is dropped.

## Test plan
- Load 3 words (A5 03 C0 00 C1 01 C2 02 46) → CPURST falls at the checksum-byte edge; DONE=1, ERR=0; IA=0/1/2 gives ID=C000/C101/C202; IA=16'h0080 gives ID=0000.
- Same frame with checksum 47 → ERR=1, CPURST=1, DONE=0, state IDLE; next correct frame → ERR clears on sync, DONE=1.
- Count byte 00, and separately count 81 (129) → ERR=1 at the count-byte edge, data words unchanged.
- Stop after the HI byte of word 1 for TIMEOUT cycles → ERR=1 at cycle TIMEOUT-1 after last RXV. A stray 00 byte afterwards is ignored in IDLE.
- In RUN, send A5 01 12 34 46 → CPURST=1 and DONE=0 at the A5 edge; after the checksum, mem[0]=1234, mem[1..2] unchanged, CPURST=0.
- Assert RST after word 0 of a 2-word frame → CPURST=1, ERR=0, DONE=0, state IDLE. A following full frame loads correctly.
